// File: rtl/peripheral_bcd2bin.sv
// Memory-mapped BCD-to-binary converter: ten packed BCD digits in, 32-bit unsigned result out.
// One digit is folded into a 36-bit accumulator per clock; overflow and invalid-digit flags are kept.
module peripheral_bcd2bin (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_in,
   input  logic        cs,
   input  logic [4:2]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [31:0] d_out
);

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_e;

   localparam logic [2:0] A_BCD_LO = 3'd0;
   localparam logic [2:0] A_BCD_HI = 3'd1;
   localparam logic [2:0] A_CTRL   = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_RESULT = 3'd4;

   state_e      state_q,    state_d;
   logic [31:0] bcd_lo_q,   bcd_lo_d;
   logic [7:0]  bcd_hi_q,   bcd_hi_d;
   logic        ctrl_q,     ctrl_d;
   logic [39:0] shift_q,    shift_d;
   logic [35:0] acc_q,      acc_d;
   logic [3:0]  cnt_q,      cnt_d;
   logic [31:0] result_q,   result_d;
   logic        invalid_q,  invalid_d;
   logic        overflow_q, overflow_d;
   logic        ready_q,    ready_d;
   logic [31:0] d_out_q,    d_out_d;

   logic        wr_en;
   logic        rd_en;
   logic        start;
   logic [3:0]  digit;
   logic [35:0] acc_next;

   assign wr_en = cs & wr;
   assign rd_en = cs & rd;

   // Start is edge-like: software must drop ctrl to 0 before another start is accepted.
   assign start = wr_en && (addr == A_CTRL) && d_in[0] && !ctrl_q && (state_q == IDLE);

   assign digit    = shift_q[39:36];
   assign acc_next = (acc_q << 3) + (acc_q << 1) + {32'b0, digit};

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      state_d    = state_q;
      bcd_lo_d   = bcd_lo_q;
      bcd_hi_d   = bcd_hi_q;
      ctrl_d     = ctrl_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      invalid_d  = invalid_q;
      overflow_d = overflow_q;
      ready_d    = ready_q;
      d_out_d    = 32'b0;

      if (wr_en) begin
         case (addr)
            A_BCD_LO: bcd_lo_d = d_in;
            A_BCD_HI: bcd_hi_d = d_in[7:0];
            A_CTRL:   ctrl_d   = d_in[0];
            default:  ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CONV;
               shift_d    = {bcd_hi_q, bcd_lo_q};
               acc_d      = 36'b0;
               cnt_d      = 4'd0;
               invalid_d  = 1'b0;
               overflow_d = 1'b0;
               ready_d    = 1'b0;
            end
         end
         CONV: begin
            acc_d     = acc_next;
            shift_d   = shift_q << 4;
            invalid_d = invalid_q | (digit > 4'd9);
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               state_d    = IDLE;
               result_d   = acc_next[31:0];
               overflow_d = |acc_next[35:32];
               ready_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reads see the pre-edge register values, so status sampled at completion still shows busy.
      if (rd_en) begin
         case (addr)
            A_STATUS: d_out_d = {29'b0, invalid_q, overflow_q, ready_q};
            A_RESULT: d_out_d = result_q;
            default:  d_out_d = 32'b0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         bcd_lo_q   <= 32'b0;
         bcd_hi_q   <= 8'b0;
         ctrl_q     <= 1'b0;
         shift_q    <= 40'b0;
         acc_q      <= 36'b0;
         cnt_q      <= 4'd0;
         result_q   <= 32'b0;
         invalid_q  <= 1'b0;
         overflow_q <= 1'b0;
         ready_q    <= 1'b1;
         d_out_q    <= 32'b0;
      end else begin
         state_q    <= state_d;
         bcd_lo_q   <= bcd_lo_d;
         bcd_hi_q   <= bcd_hi_d;
         ctrl_q     <= ctrl_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         invalid_q  <= invalid_d;
         overflow_q <= overflow_d;
         ready_q    <= ready_d;
         d_out_q    <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_bcd2bin.sv
// Bench for peripheral_bcd2bin: directed register-level sequences plus random conversions
// checked against a decimal-arithmetic reference model.
module tb_peripheral_bcd2bin;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] d_in = 32'b0;
   logic        cs = 1'b0;
   logic [2:0]  addr = 3'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] d_out;

   int n_cmp  = 0;
   int n_fail = 0;

   peripheral_bcd2bin dut (
      .clk   (clk),
      .rst   (rst),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Bus tasks are entered at a falling edge and return at the following falling edge.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; d_in = 32'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(posedge clk);
      #1 d = d_out;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
   endtask

   // Reference: interpret the ten nibbles as decimal digits with ordinary arithmetic.
   task automatic model(input logic [7:0] hi, input logic [31:0] lo,
                        output logic [31:0] res, output logic ovf, output logic inv);
      logic [39:0] digits;
      logic [63:0] v;
      int          dg;
      digits = {hi, lo};
      v      = 64'd0;
      inv    = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         dg  = int'(digits[i*4 +: 4]);
         v   = v * 64'd10 + 64'(dg);
         inv = inv | (dg > 9);
      end
      res = v[31:0];
      ovf = (v > 64'h0000_0000_FFFF_FFFF);
   endtask

   // Poll status every cycle; returns number of cycles ready read back as 0.
   task automatic poll_ready(output int zeros);
      bit got;
      got   = 1'b0;
      zeros = 0;
      cs = 1'b1; rd = 1'b1; addr = 3'd3;
      for (int c = 0; c < 40 && !got; c++) begin
         @(posedge clk);
         #1;
         if (d_out[0]) got = 1'b1;
         else zeros++;
      end
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      if (!got) check("poll_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_conv(input string tag, input logic [7:0] hi, input logic [31:0] lo,
                           output logic [31:0] res_out, output logic [31:0] stat_out);
      logic [31:0] r;
      logic [31:0] s;
      logic [31:0] exp_res;
      logic        ovf;
      logic        inv;
      int          zeros;
      model(hi, lo, exp_res, ovf, inv);
      bus_write(3'd0, lo);
      bus_write(3'd1, {$urandom_range(0, 32'hFFFFFF)} << 8 | 32'(hi));
      bus_write(3'd2, 32'd1);
      poll_ready(zeros);
      check({tag, " ready_low_cycles"}, 32'(zeros), 32'd10);
      bus_write(3'd2, 32'd0);
      bus_read(3'd4, r);
      check({tag, " result"}, r, exp_res);
      bus_read(3'd3, s);
      check({tag, " status"}, s, {29'b0, inv, ovf, 1'b1});
      res_out  = r;
      stat_out = s;
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] s;
      logic [31:0] exp_res;
      logic [31:0] exp_a;
      logic        ovf;
      logic        inv;
      logic [7:0]  rhi;
      logic [31:0] rlo;
      int          zeros;

      // Reset state
      #1 check("reset d_out", d_out, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus_read(3'd3, s);
      check("reset status", s, 32'd1);
      bus_read(3'd4, r);
      check("reset result", r, 32'd0);

      // Directed vectors with hand-derived constants as well as the model
      run_conv("v1", 8'h00, 32'h12345678, r, s);
      check("v1 const result", r, 32'h00BC614E);
      check("v1 const status", s, 32'h1);
      run_conv("v2", 8'h42, 32'h94967295, r, s);
      check("v2 const result", r, 32'hFFFFFFFF);
      check("v2 const status", s, 32'h1);
      run_conv("v3", 8'h42, 32'h94967296, r, s);
      check("v3 const result", r, 32'h00000000);
      check("v3 const status", s, 32'h3);
      run_conv("v4", 8'h99, 32'h99999999, r, s);
      check("v4 const result", r, 32'h540BE3FF);
      check("v4 const status", s, 32'h3);
      run_conv("v5", 8'h00, 32'h0000001A, r, s);
      check("v5 const result", r, 32'h00000014);
      check("v5 const status", s, 32'h5);

      // d_out returns to 0 in a cycle without a read
      @(posedge clk);
      #1 check("idle d_out", d_out, 32'd0);
      @(negedge clk);

      // Start during CONV is ignored; bcd writes during CONV do not disturb the run
      model(8'h00, 32'h12345678, exp_a, ovf, inv);
      bus_write(3'd1, 32'h0);
      bus_write(3'd0, 32'h12345678);
      bus_write(3'd2, 32'd1);
      bus_write(3'd0, 32'h87654321);
      bus_write(3'd2, 32'd0);
      bus_write(3'd2, 32'd1);
      poll_ready(zeros);
      check("midconv ready_low_cycles", 32'(zeros), 32'd7);
      bus_read(3'd4, r);
      check("midconv result", r, exp_a);

      // ctrl still 1: writing 1 again must not start a conversion
      bus_write(3'd2, 32'd1);
      bus_read(3'd3, s);
      check("restart status", s, 32'd1);
      bus_read(3'd4, r);
      check("restart result", r, exp_a);
      bus_write(3'd2, 32'd0);

      // Reset five cycles into a conversion, with a result read held on the bus
      bus_write(3'd2, 32'd1);
      cs = 1'b1; rd = 1'b1; addr = 3'd4;
      repeat (5) @(posedge clk);
      #2 check("prereset d_out", d_out, exp_a);
      rst = 1'b0;
      #1 check("async reset d_out", d_out, 32'd0);
      cs = 1'b0; rd = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bus_read(3'd3, s);
      check("post-reset status", s, 32'd1);
      bus_read(3'd4, r);
      check("post-reset result", r, 32'd0);

      // Random conversions: mostly legal digits, occasionally arbitrary nibbles
      for (int t = 0; t < 20; t++) begin
         rhi = 8'b0;
         rlo = 32'b0;
         for (int k = 0; k < 8; k++)
            rlo[k*4 +: 4] = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
         for (int k = 0; k < 2; k++)
            rhi[k*4 +: 4] = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
         run_conv($sformatf("rnd%0d", t), rhi, rlo, r, s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
